hci_tcdm_responder: RTL and testbench



---
 rtl/hci_tcdm_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_hci_tcdm_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_tcdm_responder.sv
// TCDM target endpoint: word-addressed scratchpad with fixed read latency,
// an in-order response FIFO with bypass, and credit-based grant throttling.
module hci_tcdm_responder #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned IW         = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LAT        = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            tcdm_req_i,
    output logic            tcdm_gnt_o,
    input  logic [AW-1:0]   tcdm_add_i,
    input  logic            tcdm_wen_i,
    input  logic [DW-1:0]   tcdm_data_i,
    input  logic [DW/8-1:0] tcdm_be_i,
    input  logic [IW-1:0]   tcdm_id_i,
    output logic [DW-1:0]   tcdm_r_data_o,
    output logic            tcdm_r_valid_o,
    input  logic            tcdm_r_ready_i,
    output logic [IW-1:0]   tcdm_r_id_o,
    output logic            err_o
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFFW = $clog2(BW);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IDXW-1:0] idx;
    logic            oor;
    logic            addr_unused;

    assign idx         = tcdm_add_i[OFFW +: IDXW];
    assign addr_unused = ^tcdm_add_i[OFFW-1:0];

    generate
        if (OFFW + IDXW < AW) begin : g_oor
            assign oor = |tcdm_add_i[AW-1:OFFW+IDXW];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant, handshakes, credits and error flag
    // ------------------------------------------------------------------
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;
    logic          hs, rd_hs, wr_hs;
    logic          r_valid, pop;

    assign tcdm_gnt_o = tcdm_req_i & ~stall_i & (credits_q != '0);
    assign hs         = tcdm_req_i & tcdm_gnt_o;
    assign rd_hs      = hs & tcdm_wen_i;
    assign wr_hs      = hs & ~tcdm_wen_i;

    // Credits track free FIFO slots minus reads still travelling the pipeline.
    always_comb begin
        credits_d = credits_q;
        unique case ({rd_hs, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
        err_d = err_q | (hs & oor);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q <= CW'(FIFO_DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Memory: byte-lane writes, registered read at the handshake edge.
    // Not reset so that committed data survives a reset pulse.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_hs && !oor) begin
            for (int b = 0; b < BW; b++) begin
                if (tcdm_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
                end
            end
        end
        if (rd_hs && !oor) begin
            rd_data_q <= mem_q[idx];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: the RAM read register is stage 0, followed by LAT-1
    // shift stages. The pipeline never stalls; credits guarantee that its
    // output always has somewhere to go.
    // ------------------------------------------------------------------
    logic [LAT-1:0] stage_valid;
    logic [IW-1:0]  stage_id   [LAT];
    logic [DW-1:0]  stage_data [LAT];

    logic          s0_valid_q, s0_valid_d;
    logic          s0_oor_q, s0_oor_d;
    logic [IW-1:0] s0_id_q, s0_id_d;

    always_comb begin
        s0_valid_d = rd_hs;
        s0_oor_d   = oor;
        s0_id_d    = tcdm_id_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_oor_q   <= 1'b0;
            s0_id_q    <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_oor_q   <= s0_oor_d;
            s0_id_q    <= s0_id_d;
        end
    end

    assign stage_valid[0] = s0_valid_q;
    assign stage_id[0]    = s0_id_q;
    assign stage_data[0]  = s0_oor_q ? '0 : rd_data_q;

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_pipe
            logic          valid_q;
            logic [IW-1:0] id_q;
            logic [DW-1:0] data_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    id_q    <= '0;
                end else begin
                    valid_q <= stage_valid[gi-1];
                    id_q    <= stage_id[gi-1];
                end
            end

            always_ff @(posedge clk_i) begin
                data_q <= stage_data[gi-1];
            end

            assign stage_valid[gi] = valid_q;
            assign stage_id[gi]    = id_q;
            assign stage_data[gi]  = data_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO with bypass: an empty FIFO presents the pipeline output
    // directly; anything not consumed that cycle is queued.
    // ------------------------------------------------------------------
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [IW-1:0] fifo_id_q   [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, push, fifo_pop;
    logic          last_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign last_valid = stage_valid[LAT-1];
    assign fifo_empty = (count_q == '0);
    assign r_valid    = ~fifo_empty | last_valid;
    assign pop        = r_valid & tcdm_r_ready_i;
    assign push       = last_valid & ~(fifo_empty & tcdm_r_ready_i);
    assign fifo_pop   = pop & ~fifo_empty;

    always_comb begin
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = fifo_pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        unique case ({push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wptr_q] <= stage_data[LAT-1];
            fifo_id_q[wptr_q]   <= stage_id[LAT-1];
        end
    end

    // Idle outputs are forced to zero so a reset clears them immediately.
    always_comb begin
        tcdm_r_valid_o = r_valid;
        tcdm_r_data_o  = '0;
        tcdm_r_id_o    = '0;
        if (!fifo_empty) begin
            tcdm_r_data_o = fifo_data_q[rptr_q];
            tcdm_r_id_o   = fifo_id_q[rptr_q];
        end else if (last_valid) begin
            tcdm_r_data_o = stage_data[LAT-1];
            tcdm_r_id_o   = stage_id[LAT-1];
        end
    end

endmodule

// File: tb/tb_hci_tcdm_responder.sv
// Scoreboard bench for hci_tcdm_responder: a reference memory model pushes
// expected responses at each read handshake; the monitor pops and compares.
module tb_hci_tcdm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  id;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_id;
    logic        err;

    hci_tcdm_responder #(
        .DW(32), .AW(32), .IW(8), .DEPTH(1024), .LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_data_i    (wdata),
        .tcdm_be_i      (be),
        .tcdm_id_i      (id),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_ready_i (r_ready),
        .tcdm_r_id_o    (r_id),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm [1024];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_resp = 0;
    int          first_pop_cyc = 0;
    int          last_pop_cyc = 0;
    bit          mark_first = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [7:0]  prev_id;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor / scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [9:0]  widx;
        logic        w_oor;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", r_valid, 1'b1);
                chk("hold_data", r_data, prev_data);
                chk("hold_id", r_id, prev_id);
            end
            prev_hold = r_valid & ~r_ready;
            prev_data = r_data;
            prev_id   = r_id;
            if (!req || stall) chk("gnt_idle", gnt, 1'b0);
            if (r_valid && r_ready) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_data", r_data, e.data);
                    chk("resp_id", r_id, e.id);
                end
                $display("resp id=%0h data=%08h cycle=%0d", r_id, r_data, cyc);
                last_rdata   = r_data;
                n_resp++;
                last_pop_cyc = cyc;
                if (mark_first) begin
                    first_pop_cyc = cyc;
                    mark_first    = 1'b0;
                end
            end
            if (req && gnt) begin
                widx  = add[11:2];
                w_oor = |add[31:12];
                if (wen) begin
                    e.data = w_oor ? 32'h0 : mm[widx];
                    e.id   = id;
                    sb.push_back(e);
                end else if (!w_oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mm[widx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Hold request until granted, then finish the handshake edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [7:0] i);
        bit got = 1'b0;
        req = 1'b1; wen = w; add = a; wdata = d; be = b; id = i;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = gnt;
        end
        if (!got) chk("gnt_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Drive reads continuously for ncyc cycles with r_ready held; returns grant count.
    task automatic stream_reads(input int ncyc, input logic [31:0] base,
                                input logic [7:0] id0, inout int nxt);
        for (int c = 0; c < ncyc; c++) begin
            req = 1'b1; wen = 1'b1; add = base + 32'(4 * nxt); id = id0 + 8'(nxt);
            @(negedge clk);
            if (gnt) nxt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nxt;
        int start_cyc;
        int resp0;

        rst = 1'b1; stall = 1'b0; req = 1'b0; add = '0; wen = 1'b0;
        wdata = '0; be = '0; id = '0; r_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", gnt, 1'b0);
        chk("rst_rvalid", r_valid, 1'b0);
        chk("rst_rdata", r_data, 32'h0);
        chk("rst_rid", r_id, 8'h0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read next cycle; exact latency of 2
        issue(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 8'h0);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 8'd5);
        @(negedge clk);
        chk("lat_early", r_valid, 1'b0);
        @(negedge clk);
        chk("lat_exact", r_valid, 1'b1);
        chk("wr_rd_data", r_data, 32'hDEADBEEF);
        chk("wr_rd_id", r_id, 8'd5);
        drain();

        // Byte enables
        issue(1'b0, 32'h104, 32'h11223344, 4'hF, 8'h0);
        issue(1'b0, 32'h104, 32'hAABBCCDD, 4'h5, 8'h0);
        issue(1'b1, 32'h104, 32'h0, 4'h0, 8'd7);
        drain();
        chk("be_merge", last_rdata, 32'h11BB33DD);

        // Backpressure: 8 reads against a stalled consumer
        for (int k = 0; k < 8; k++) issue(1'b0, 32'h200 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF, 8'h0);
        drain();
        resp0 = n_resp;
        r_ready = 1'b0;
        nxt = 0;
        stream_reads(10, 32'h200, 8'h10, nxt);
        chk("bp_grants", nxt, 4);
        @(negedge clk);
        chk("bp_gnt_low", gnt, 1'b0);
        @(posedge clk); #1;
        r_ready = 1'b1;
        for (int c = 0; c < 50 && nxt < 8; c++) stream_reads(1, 32'h200, 8'h10, nxt);
        req = 1'b0;
        chk("bp_all_granted", nxt, 8);
        drain();
        chk("bp_resp_count", n_resp - resp0, 8);

        // Throughput: 100 consecutive reads with r_ready high
        resp0      = n_resp;
        mark_first = 1'b1;
        start_cyc  = cyc;
        for (int k = 0; k < 100; k++) issue(1'b1, 32'h200 + 32'(4 * (k % 8)), 32'h0, 4'h0, 8'(k));
        chk("tp_cycles", cyc - start_cyc, 100);
        drain();
        chk("tp_resp_count", n_resp - resp0, 100);
        chk("tp_no_bubble", last_pop_cyc - first_pop_cyc, 99);

        // Out-of-range accesses
        issue(1'b0, 32'h0, 32'h0BADC0DE, 4'hF, 8'h0);
        issue(1'b1, 32'h1000, 32'h0, 4'h0, 8'd9);
        drain();
        chk("oor_rdata", last_rdata, 32'h0);
        chk("oor_err_set", err, 1'b1);
        issue(1'b0, 32'h1000, 32'h55555555, 4'hF, 8'h0);
        issue(1'b1, 32'h0, 32'h0, 4'h0, 8'd10);
        drain();
        chk("oor_wr_dropped", last_rdata, 32'h0BADC0DE);
        chk("oor_err_sticky", err, 1'b1);

        // stall_i suppresses grant; release grants the same cycle
        stall = 1'b1;
        req = 1'b1; wen = 1'b1; add = 32'h100; id = 8'h33;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_gnt", gnt, 1'b0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release", gnt, 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();
        chk("stall_rdata", last_rdata, 32'hDEADBEEF);

        // Reset with reads outstanding
        issue(1'b0, 32'h300, 32'hCAFEF00D, 4'hF, 8'h0);
        drain();
        r_ready = 1'b0;
        for (int k = 0; k < 3; k++) issue(1'b1, 32'h300, 32'h0, 4'h0, 8'(8'h40 + k));
        @(negedge clk);
        chk("pre_rst_rvalid", r_valid, 1'b1);
        #1;
        rst = 1'b1;
        sb.delete();
        prev_hold = 1'b0;
        #1;
        chk("midrst_rvalid", r_valid, 1'b0);
        chk("midrst_err", err, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        nxt = 0;
        stream_reads(8, 32'h300, 8'h50, nxt);
        req = 1'b0;
        chk("rst_credits", nxt, 4);
        // stream_reads advances the address; only word 0x300 was written
        r_ready = 1'b1;
        drain();
        issue(1'b1, 32'h300, 32'h0, 4'h0, 8'h60);
        drain();
        chk("rst_mem_persist", last_rdata, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
